// File: rtl/am29_ifetch_pkg.sv
// Shared types and default sizing for the am29 instruction fetch queue.
package am29_ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int AW_DEF    = 4;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/am29_ifetch_if.sv
// Memory read bus between the fetch unit (master) and microprogram memory (slave).
interface am29_ifetch_if #(
    parameter int AW = 4,
    parameter int DW = 8
) ();
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          mack;
    logic [DW-1:0] mdata;

    modport master (output mreq, output maddr, input mack, input mdata);
    modport slave  (input mreq, input maddr, output mack, output mdata);
endinterface

// File: rtl/am29_ifetch_fifo.sv
// Fetch queue storage: DEPTH-entry circular buffer with clear, occupancy 0..DEPTH.
module am29_ifetch_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          cp,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    // Clear wins over everything; pop is ignored when nothing is queued.
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count_reg != '0);

    always_ff @(posedge cp) begin
        if (rst || clear) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + PW'(1);
            if (do_pop)  rptr_reg <= rptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge cp) begin
        if (do_push) mem_reg[wptr_reg] <= din;
    end

    assign dout  = mem_reg[rptr_reg];
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;
endmodule

// File: rtl/am29_ifetch.sv
// Prefetch unit between an am2932-style sequencer and microprogram memory.
// Optional occupancy output cnt is enabled with macro AM29_IFETCH_CNT_EN.
module am29_ifetch
    import am29_ifetch_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   cp,
    input  logic                   rst,
    input  logic [AW-1:0]          y,
    input  logic                   yv,
    output logic                   yrdy,
    input  logic                   flush,
    am29_ifetch_if.master          mem,
    output logic [DW-1:0]          q,
    output logic [AW-1:0]          qa,
    output logic                   qv,
    input  logic                   qrdy,
    output logic                   empty,
`ifdef AM29_IFETCH_CNT_EN
    output logic [$clog2(DEPTH):0] cnt,
`endif
    output logic                   full_
);
    state_t        state_reg, state_next;
    logic [AW-1:0] maddr_reg, maddr_next;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge cp) begin
        if (rst) begin
            state_reg <= IDLE;
            maddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            maddr_reg <= maddr_next;
        end
    end

    // Accept only when a queue slot is free, so the eventual push always fits.
    assign yrdy = (state_reg == IDLE) && !flush && !fifo_full;

    always_comb begin
        state_next = state_reg;
        maddr_next = maddr_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (yv && yrdy) begin
                    state_next = REQ;
                    maddr_next = y;
                end
            end
            REQ: begin
                // A flush coinciding with mack completes the read but drops its data.
                if (mem.mack) begin
                    push       = !flush;
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (mem.mack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem.mreq  = (state_reg != IDLE);
    assign mem.maddr = maddr_reg;

    am29_ifetch_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .cp    (cp),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (qrdy),
        .din   ({maddr_reg, mem.mdata}),
        .dout  ({qa, q}),
        .full  (fifo_full),
        .empty (fifo_empty),
`ifdef AM29_IFETCH_CNT_EN
        .count (cnt)
`else
        .count ()
`endif
    );

    assign qv    = !fifo_empty;
    assign empty = fifo_empty;
    assign full_ = !fifo_full;
endmodule
